// File: rtl/spi_mem_pkg.sv
// Shared types for the SPI-to-memory bridge.
//   cmd_e     : 2-bit frame command field
//   state_e   : SPI frame FSM states
//   FRAME_LEN : total serial frame length, {cmd[1:0], payload[DATA_W-1:0]}
package spi_mem_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_e;

  function automatic int FRAME_LEN(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/spi_mem_core.sv
// Memory core of the SPI bridge: synchronous single-port DATA_W x MEM_DEPTH
// memory plus the write/read address registers.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset (clears memory too)
//   op_valid     : one-cycle command strobe from the frame decoder
//   op_cmd       : command of the strobed frame
//   op_payload   : payload of the strobed frame
//   rd_next      : pulse at the end of a completed read-out (address advance)
//   wr_in_range  : current write address is below MEM_DEPTH
//   dout         : registered read data (0 for an out-of-range address)
//   tx_valid     : one-cycle pulse, dout holds fresh read data
//   rd_err       : registered with dout, read address was out of range
// Configuration macro: SPI_MEM_AUTOINC_EN (address auto-increment).
//
// Handshake: op_valid is a single-cycle strobe and the core accepts every
// strobe on the edge it is seen (always ready), so no ready signal exists;
// tx_valid is likewise a strobe that the consumer must take when it appears.
module spi_mem_core
  import spi_mem_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  input  cmd_e              op_cmd,
  input  logic [DATA_W-1:0] op_payload,
  input  logic              rd_next,
  output logic              wr_in_range,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              rd_err
);

  localparam logic [DATA_W:0] DEPTH_V = (DATA_W+1)'(MEM_DEPTH);

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  // Address registers keep the full payload width so an out-of-range value
  // is remembered and can be flagged when it is used.
  logic [DATA_W-1:0] wr_addr;
  logic [DATA_W-1:0] rd_addr;
  logic              rd_in_range;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_V);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_V);

`ifdef SPI_MEM_AUTOINC_EN
  localparam logic [DATA_W-1:0] LAST_V = DATA_W'(MEM_DEPTH - 1);

  function automatic logic [DATA_W-1:0] wrap_inc(input logic [DATA_W-1:0] a);
    return (a == LAST_V) ? '0 : a + 1'b1;
  endfunction
`else
  logic unused_rd_next;
  assign unused_rd_next = rd_next;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      wr_addr  <= '0;
      rd_addr  <= '0;
      dout     <= '0;
      tx_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      if (op_valid) begin
        unique case (op_cmd)
          CMD_WR_ADDR: wr_addr <= op_payload;
          CMD_WR_DATA: begin
            if (wr_in_range) begin
              mem[wr_addr[ADDR_W-1:0]] <= op_payload;
`ifdef SPI_MEM_AUTOINC_EN
              wr_addr <= wrap_inc(wr_addr);
`endif
            end
          end
          CMD_RD_ADDR: rd_addr <= op_payload;
          CMD_RD_DATA: begin
            tx_valid <= 1'b1;
            rd_err   <= !rd_in_range;
            dout     <= rd_in_range ? mem[rd_addr[ADDR_W-1:0]] : '0;
          end
          default: ;
        endcase
      end
`ifdef SPI_MEM_AUTOINC_EN
      // Advance only once the word has been fully shifted out.
      if (rd_next && rd_in_range) rd_addr <= wrap_inc(rd_addr);
`endif
    end
  end

endmodule

// File: rtl/spi_mem_wrapper_p.sv
// SPI-slave-to-memory bridge. Decodes {cmd[1:0], payload} frames (MSB first)
// into write-address / write-data / read-address / read-data operations on
// spi_mem_core and serializes read data on MISO.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   MOSI, SS_n   : serial data in, active-low frame select
//   MISO         : serial read data, MSB first, 0 when idle
//   frame_done   : one-cycle pulse per accepted frame
//   frame_err    : one-cycle pulse on command mismatch or address out of range
//   dbg_state    : current FSM state
// Configuration macro: SPI_MEM_AUTOINC_EN (address auto-increment, read
// address stays valid across read-outs). DATA_W must be at least 2.
module spi_mem_wrapper_p
  import spi_mem_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   MOSI,
  input  logic   SS_n,
  output logic   MISO,
  output logic   frame_done,
  output logic   frame_err,
  output state_e dbg_state
);

  localparam int FL    = FRAME_LEN(DATA_W);
  localparam int CNT_W = $clog2(FL + 1);
  localparam int TXC_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] FL_V = CNT_W'(FL);

  state_e            state, state_n;
  logic [CNT_W-1:0]  bit_cnt;
  logic [FL-1:0]     rx_sr;
  logic              rd_addr_vld;
  logic              done;      // frame fully received, waiting for SS_n high
  logic              reading;   // read-out requested and not yet finished
  logic [DATA_W-1:0] tx_sr;
  logic [TXC_W-1:0]  tx_cnt;    // bits still to present after the current one

  logic              shift_en, exec, abort_rd;
  logic              mismatch, op_valid, lsb_load, done_pulse, err_pulse;
  cmd_e              rx_cmd;
  logic [DATA_W-1:0] rx_payload;
  logic              wr_in_range, tx_valid, rd_err;
  logic [DATA_W-1:0] dout;

  assign dbg_state  = state;
  assign rx_cmd     = cmd_e'(rx_sr[FL-1 -: 2]);
  assign rx_payload = rx_sr[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // A fully received frame is executed even if SS_n rises on that same
  // cycle; SS_n high only discards a frame that is still short of bits.
  always_comb begin
    state_n  = state;
    shift_en = 1'b0;
    exec     = 1'b0;
    abort_rd = 1'b0;
    unique case (state)
      IDLE: if (!SS_n) state_n = CHK_CMD;
      CHK_CMD: begin
        if (SS_n) state_n = IDLE;
        else begin
          shift_en = 1'b1;
          if (!MOSI)            state_n = WRITE;
          else if (rd_addr_vld) state_n = READ_DATA;
          else                  state_n = READ_ADD;
        end
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (!done) begin
          if (bit_cnt == FL_V) exec = 1'b1;
          else if (SS_n)       state_n = IDLE;
          else                 shift_en = 1'b1;
        end else if (SS_n) begin
          state_n  = IDLE;
          abort_rd = reading;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign mismatch = ((state == READ_ADD)  && (rx_cmd == CMD_RD_DATA)) ||
                    ((state == READ_DATA) && (rx_cmd == CMD_RD_ADDR));
  assign op_valid = exec && !mismatch;
  assign lsb_load = reading && (tx_cnt == TXC_W'(1)) && !abort_rd;

  assign done_pulse = (op_valid && (rx_cmd != CMD_RD_DATA) &&
                       ((rx_cmd != CMD_WR_DATA) || wr_in_range)) ||
                      (lsb_load && !rd_err);
  assign err_pulse  = (exec && mismatch) ||
                      (op_valid && (rx_cmd == CMD_WR_DATA) && !wr_in_range) ||
                      (lsb_load && rd_err);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      rx_sr       <= '0;
      rd_addr_vld <= 1'b0;
      done        <= 1'b0;
      reading     <= 1'b0;
      tx_sr       <= '0;
      tx_cnt      <= '0;
      MISO        <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_done <= done_pulse;
      frame_err  <= err_pulse;

      if (state_n == IDLE) begin
        bit_cnt <= '0;
        done    <= 1'b0;
      end else if (exec) begin
        done <= 1'b1;
      end else if (shift_en) begin
        rx_sr   <= {rx_sr[FL-2:0], MOSI};
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (abort_rd || lsb_load)                       reading <= 1'b0;
      else if (op_valid && (rx_cmd == CMD_RD_DATA))   reading <= 1'b1;

      if (abort_rd)                                   rd_addr_vld <= 1'b0;
      else if (op_valid && (rx_cmd == CMD_RD_ADDR))   rd_addr_vld <= 1'b1;
`ifndef SPI_MEM_AUTOINC_EN
      else if (lsb_load)                              rd_addr_vld <= 1'b0;
`endif

      // Serializer: load MSB on tx_valid, then one bit per cycle.
      if (abort_rd) begin
        tx_cnt <= '0;
        MISO   <= 1'b0;
      end else if (reading && tx_valid) begin
        MISO   <= dout[DATA_W-1];
        tx_sr  <= {dout[DATA_W-2:0], 1'b0};
        tx_cnt <= TXC_W'(DATA_W - 1);
      end else if (tx_cnt != '0) begin
        MISO   <= tx_sr[DATA_W-1];
        tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
        tx_cnt <= tx_cnt - 1'b1;
      end else begin
        MISO <= 1'b0;
      end
    end
  end

  spi_mem_core #(
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_valid    (op_valid),
    .op_cmd      (rx_cmd),
    .op_payload  (rx_payload),
    .rd_next     (lsb_load),
    .wr_in_range (wr_in_range),
    .dout        (dout),
    .tx_valid    (tx_valid),
    .rd_err      (rd_err)
  );

endmodule

// File: tb/tb_spi_mem_wrapper_p.sv
// Bench for spi_mem_wrapper_p (DATA_W=8, MEM_DEPTH=200 so that out-of-range
// addresses are reachable). A word-level model (memory array, two addresses,
// read-address-valid flag) predicts per-frame output waveforms.
module tb_spi_mem_wrapper_p;
  import spi_mem_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 200;
  localparam int FL    = W + 2;
  localparam int WIN   = W + 4;

  // clock / reset
  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  logic   mosi  = 1'b0;
  logic   ss_n  = 1'b1;
  logic   miso, frame_done, frame_err;
  state_e dbg_state;

  always #5 clk = ~clk;

  spi_mem_wrapper_p #(.DATA_W(W), .MEM_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MOSI       (mosi),
    .SS_n       (ss_n),
    .MISO       (miso),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .dbg_state  (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  int frame_no = 0;

  // reference model
  logic [W-1:0] m_mem [256];
  int           m_wr, m_rd;
  bit           m_vld;

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_mem[i]) m_mem[i] = '0;
    m_wr  = 0;
    m_rd  = 0;
    m_vld = 0;
  endtask

  // Expected waveforms indexed by j = cycles after the last MOSI bit edge.
  task automatic predict(input logic [1:0] cmd, input logic [W-1:0] pay, input int cut_j,
                         output logic [WIN-1:0] e_miso, output logic [WIN-1:0] e_done,
                         output logic [WIN-1:0] e_err);
    logic [W-1:0] data;
    bit ok;
    e_miso = '0; e_done = '0; e_err = '0;
    if (cmd == 2'b00) begin
      m_wr = int'(pay);
      e_done[1] = 1'b1;
    end else if (cmd == 2'b01) begin
      if (m_wr < DEPTH) begin
        m_mem[m_wr] = pay;
`ifdef SPI_MEM_AUTOINC_EN
        m_wr = (m_wr + 1) % DEPTH;
`endif
        e_done[1] = 1'b1;
      end else e_err[1] = 1'b1;
    end else if (!m_vld) begin
      if (cmd == 2'b10) begin
        m_rd = int'(pay); m_vld = 1; e_done[1] = 1'b1;
      end else e_err[1] = 1'b1;
    end else if (cmd == 2'b10) begin
      e_err[1] = 1'b1;
    end else begin
      ok   = (m_rd < DEPTH);
      data = ok ? m_mem[m_rd] : '0;
      for (int b = 0; b < W; b++)
        if (cut_j == 0 || 2 + b <= cut_j) e_miso[2+b] = data[W-1-b];
      if (cut_j == 0) begin
        if (ok) e_done[W+1] = 1'b1; else e_err[W+1] = 1'b1;
`ifdef SPI_MEM_AUTOINC_EN
        if (ok) m_rd = (m_rd + 1) % DEPTH;
`else
        m_vld = 0;
`endif
      end else m_vld = 0;
    end
  endtask

  // driver tasks
  task automatic drive_bits(input logic [FL-1:0] bits, input int nbits);
    @(negedge clk); ss_n = 1'b0; mosi = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk); mosi = bits[FL-1-k];
    end
  endtask

  // nbits < FL: SS_n rises after nbits bits. cut_j != 0: SS_n rises after
  // sample j=cut_j (read-out abort).
  task automatic run_frame(input logic [1:0] cmd, input logic [W-1:0] pay,
                           input int nbits, input int cut_j);
    logic [WIN-1:0] g_miso, g_done, g_err, e_miso, e_done, e_err;
    string tag;
    frame_no++;
    tag = $sformatf("frame%0d_cmd%0d", frame_no, cmd);
    e_miso = '0; e_done = '0; e_err = '0;
    if (nbits == FL) predict(cmd, pay, cut_j, e_miso, e_done, e_err);
    drive_bits({cmd, pay}, nbits);
    for (int j = 0; j < WIN; j++) begin
      @(negedge clk);
      g_miso[j] = miso; g_done[j] = frame_done; g_err[j] = frame_err;
      if ((nbits < FL && j == 0) || (cut_j != 0 && j == cut_j)) ss_n = 1'b1;
    end
    ss_n = 1'b1; mosi = 1'b0;
    @(negedge clk);
    check_eq({tag, "_miso"}, 64'(g_miso), 64'(e_miso));
    check_eq({tag, "_done"}, 64'(g_done), 64'(e_done));
    check_eq({tag, "_err"},  64'(g_err),  64'(e_err));
    check_eq({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  // Drops a stale read address: aborted read-out if valid, mismatch if not.
  task automatic flush_rd();
    run_frame(2'b11, '0, FL, 1);
  endtask

  task automatic reset_mid_readout();
    logic [W-1:0] exp_word;
    run_frame(2'b00, 8'h05, FL, 0);
    run_frame(2'b01, 8'hE7, FL, 0);
    flush_rd();
    run_frame(2'b10, 8'h05, FL, 0);
    exp_word = m_mem[5];
    drive_bits({2'b11, 8'h00}, FL);
    for (int j = 0; j <= 4; j++) @(negedge clk);
    check_eq("rstmid_bit3", 64'(miso), 64'(exp_word[W-3]));
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rstmid_miso",  64'(miso), 64'(0));
    check_eq("rstmid_state", 64'(dbg_state), 64'(IDLE));
    check_eq("rstmid_done",  64'(frame_done), 64'(0));
    rst_n = 1'b1; ss_n = 1'b1; mosi = 1'b0;
    model_reset();
    @(negedge clk);
    run_frame(2'b11, 8'h00, FL, 0);   // read address no longer valid
    run_frame(2'b10, 8'h05, FL, 0);
    run_frame(2'b11, 8'h00, FL, 0);   // memory cleared
  endtask

  initial begin
    logic [1:0]   cmd;
    logic [W-1:0] pay;
    int           nb, cut;

    model_reset();
    rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_miso",  64'(miso), 64'(0));
    check_eq("rst_done",  64'(frame_done), 64'(0));
    check_eq("rst_err",   64'(frame_err), 64'(0));
    check_eq("rst_state", 64'(dbg_state), 64'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(2'b10, 8'h00, FL, 0);
    run_frame(2'b11, 8'h00, FL, 0);

    // basic write then read-back of 0x5C
    run_frame(2'b00, 8'h1A, FL, 0);
    run_frame(2'b01, 8'h5C, FL, 0);
    flush_rd();
    run_frame(2'b10, 8'h1A, FL, 0);
    run_frame(2'b11, 8'h00, FL, 0);

    // consecutive writes
    run_frame(2'b00, 8'h10, FL, 0);
    run_frame(2'b01, 8'hAA, FL, 0);
    run_frame(2'b01, 8'hBB, FL, 0);
    flush_rd();
`ifdef SPI_MEM_AUTOINC_EN
    run_frame(2'b10, 8'h11, FL, 0);
`else
    run_frame(2'b10, 8'h10, FL, 0);
`endif
    run_frame(2'b11, 8'h00, FL, 0);

    // partial frame is discarded; then command mismatch
    run_frame(2'b00, 8'h20, FL, 0);
    run_frame(2'b01, 8'h77, FL, 0);
    run_frame(2'b01, 8'h3C, 5, 0);
    flush_rd();
    run_frame(2'b10, 8'h20, FL, 0);
    run_frame(2'b10, 8'h33, FL, 0);
    run_frame(2'b11, 8'h00, FL, 0);

    // out-of-range address
    run_frame(2'b00, 8'hC8, FL, 0);
    run_frame(2'b01, 8'h11, FL, 0);
    flush_rd();
    run_frame(2'b10, 8'hC8, FL, 0);
    run_frame(2'b11, 8'h00, FL, 0);

    // top-of-range write, read-out abort
    run_frame(2'b00, 8'hC7, FL, 0);
    run_frame(2'b01, 8'h96, FL, 0);
    run_frame(2'b01, 8'h69, FL, 0);
    flush_rd();
    run_frame(2'b10, 8'hC7, FL, 0);
    run_frame(2'b11, 8'h00, FL, 4);
    run_frame(2'b11, 8'h00, FL, 0);

    reset_mid_readout();

    repeat (200) begin
      cmd = 2'($urandom_range(0, 3));
      if (cmd[0] == 1'b0 && $urandom_range(0, 5) != 0) pay = W'($urandom_range(0, 15));
      else                                            pay = W'($urandom_range(0, 255));
      nb  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, FL - 1) : FL;
      cut = (cmd == 2'b11 && $urandom_range(0, 7) == 0) ? $urandom_range(1, W) : 0;
      run_frame(cmd, pay, nb, cut);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
